// File: rtl/reset_seq_regf.sv
// Register file with a per-channel soft-reset sequencer (IDLE/ASSERT/WAIT/DONE).
// Define RESET_SEQ_REGF_TIMEOUT_EN to bound the WAIT phase and build STATUS.timeout.
module reset_seq_regf #(
  parameter int CHANNELS   = 4,
  parameter int ADDR_WIDTH = 13,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  main_clk_i,
  input  logic                  main_rst_i,
  input  logic                  mem_ena_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic                  mem_wena_i,
  input  logic [31:0]           mem_wdata_i,
  output logic [31:0]           mem_rdata_o,
  output logic                  mem_err_o,
  output logic [CHANNELS-1:0]   regf_ctrl_ena_rval_o,
  input  logic [CHANNELS-1:0]   regf_ctrl_busy_rbus_i,
  output logic [CHANNELS-1:0]   soft_rst_o,
  output logic                  seq_done_o,
  input  logic                  soft_rst_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_BUSY   = 2'd1;
  localparam logic [1:0] REG_SRST   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;
  localparam logic [7:0] RST_LAST   = 8'(RST_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] ena_q, ena_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] act_q, act_d;
  logic [CHANNELS-1:0] ena_out_q, ena_out_d;
  logic [CHANNELS-1:0] srst_out_q, srst_out_d;
  logic                done_q, done_d;
  logic [7:0]          rst_cnt_q, rst_cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                addr_ok_s;
  logic                wr_s;
  logic [CHANNELS-1:0] wmask_s;
  logic [31:0]         rd_val_s;
  logic                timeout_s;
  logic                unused_s;

`ifdef RESET_SEQ_REGF_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  assign timeout_s = timeout_q;
`else
  assign timeout_s = 1'b0;
`endif

  // Only word-aligned offsets 0x0..0xC are legal; everything above bit 3 must be zero.
  assign addr_ok_s = (mem_addr_i[1:0] == 2'b00) && ((mem_addr_i >> 4) == '0);
  assign wr_s      = mem_ena_i & mem_wena_i & addr_ok_s;
  assign wmask_s   = mem_wdata_i[CHANNELS-1:0];
  assign unused_s  = ^mem_wdata_i;

  always_comb begin
    rd_val_s = 32'd0;
    case (mem_addr_i[3:2])
      REG_CTRL:   rd_val_s = 32'(ena_q);
      REG_BUSY:   rd_val_s = 32'(regf_ctrl_busy_rbus_i);
      REG_SRST:   rd_val_s = 32'(pend_q | act_q);
      REG_STATUS: rd_val_s = {30'd0, timeout_s, (state_q != ST_IDLE)};
      default:    rd_val_s = 32'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ena_d     = ena_q;
    pend_d    = pend_q;
    act_d     = act_q;
    rst_cnt_d = rst_cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
`ifdef RESET_SEQ_REGF_TIMEOUT_EN
    wait_cnt_d = 16'd0;
    timeout_d  = timeout_q;
`endif

    if (mem_ena_i) begin
      err_d = ~addr_ok_s;
      if (!mem_wena_i) begin
        rdata_d = addr_ok_s ? rd_val_s : 32'd0;
      end else begin
        rdata_d = rdata_q;
      end
    end else begin
      err_d = err_q;
    end

    if (wr_s) begin
      case (mem_addr_i[3:2])
        REG_CTRL: ena_d  = wmask_s;
        REG_SRST: pend_d = pend_q | wmask_s;
        REG_STATUS: begin
`ifdef RESET_SEQ_REGF_TIMEOUT_EN
          if (mem_wdata_i[1]) begin
            timeout_d = 1'b0;
          end else begin
            timeout_d = timeout_q;
          end
`endif
        end
        default: ena_d = ena_q;
      endcase
    end else begin
      pend_d = pend_q;
    end

    // A write landing in IDLE is folded into pend_d so it starts on the very next cycle.
    case (state_q)
      ST_IDLE: begin
        rst_cnt_d = 8'd0;
        if (pend_d != '0) begin
          act_d   = pend_d;
          pend_d  = '0;
          state_d = ST_ASSERT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        if (rst_cnt_q == RST_LAST) begin
          rst_cnt_d = 8'd0;
          state_d   = ST_WAIT;
        end else begin
          rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end
      ST_WAIT: begin
        if ((regf_ctrl_busy_rbus_i & act_q) == '0) begin
          state_d = ST_DONE;
        end else begin
`ifdef RESET_SEQ_REGF_TIMEOUT_EN
          if (wait_cnt_q == WAIT_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            wait_cnt_d = wait_cnt_q + 16'd1;
          end
`else
          state_d = ST_WAIT;
`endif
        end
      end
      ST_DONE: begin
        act_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (soft_rst_i) begin
      state_d   = ST_IDLE;
      ena_d     = '0;
      pend_d    = '0;
      act_d     = '0;
      rst_cnt_d = 8'd0;
      rdata_d   = 32'd0;
      err_d     = 1'b0;
`ifdef RESET_SEQ_REGF_TIMEOUT_EN
      wait_cnt_d = 16'd0;
      timeout_d  = 1'b0;
`endif
    end else begin
      rst_cnt_d = rst_cnt_d;
    end

    // Outputs are decoded from next state so they leave the block straight from flops.
    srst_out_d = (state_d == ST_ASSERT) ? act_d : '0;
    done_d     = (state_d == ST_DONE);
    ena_out_d  = ena_d & ~act_d;
  end

  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      state_q    <= ST_IDLE;
      ena_q      <= '0;
      pend_q     <= '0;
      act_q      <= '0;
      ena_out_q  <= '0;
      srst_out_q <= '0;
      done_q     <= 1'b0;
      rst_cnt_q  <= 8'd0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ena_q      <= ena_d;
      pend_q     <= pend_d;
      act_q      <= act_d;
      ena_out_q  <= ena_out_d;
      srst_out_q <= srst_out_d;
      done_q     <= done_d;
      rst_cnt_q  <= rst_cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

`ifdef RESET_SEQ_REGF_TIMEOUT_EN
  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      wait_cnt_q <= 16'd0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
`endif

  assign mem_rdata_o          = rdata_q;
  assign mem_err_o            = err_q;
  assign regf_ctrl_ena_rval_o = ena_out_q;
  assign soft_rst_o           = srst_out_q;
  assign seq_done_o           = done_q;

endmodule

// File: tb/tb_reset_seq_regf.sv
// Randomised bench for reset_seq_regf against a timestamp-based reference model.
module tb_reset_seq_regf;
  localparam int CH = 4;
  localparam int AW = 13;
  localparam int R  = 4;
  localparam int TO = 8;
`ifdef RESET_SEQ_REGF_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          main_rst_i, mem_ena_i, mem_wena_i, soft_rst_i;
  logic [AW-1:0] mem_addr_i;
  logic [31:0]   mem_wdata_i, mem_rdata_o;
  logic          mem_err_o, seq_done_o;
  logic [CH-1:0] ena_o, busy_i, soft_rst_o;

  always #5 clk = ~clk;

  reset_seq_regf #(.CHANNELS(CH), .ADDR_WIDTH(AW), .RST_CYCLES(R), .TIMEOUT(TO)) dut (
    .main_clk_i(clk), .main_rst_i(main_rst_i), .mem_ena_i(mem_ena_i),
    .mem_addr_i(mem_addr_i), .mem_wena_i(mem_wena_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .mem_err_o(mem_err_o),
    .regf_ctrl_ena_rval_o(ena_o), .regf_ctrl_busy_rbus_i(busy_i),
    .soft_rst_o(soft_rst_o), .seq_done_o(seq_done_o), .soft_rst_i(soft_rst_i)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a sequence is described by its first ASSERT cycle and its DONE cycle.
  logic [CH-1:0] m_ena = '0, m_pend = '0, m_mask = '0;
  logic          m_to = 1'b0, m_seq = 1'b0;
  logic [31:0]   e_rd = 32'd0;
  logic          e_err = 1'b0;
  int            cyc = 0, t0 = 0, done_c = -1;
  int            n_srst_hi = 0, n_masked = 0, n_done = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] idx);
    case (idx)
      2'd0:    return 32'(m_ena);
      2'd1:    return 32'(busy_i);
      2'd2:    return 32'(m_pend | m_mask);
      default: return {30'd0, m_to, m_seq};
    endcase
  endfunction

  task automatic step();
    logic [CH-1:0] n_ena, n_pend, wbits, e_srst;
    logic          n_to, ok;
    int            p, c;
    @(posedge clk);
    cyc++;
    c = cyc;
    p = c - 1;
    if (main_rst_i || soft_rst_i) begin
      m_ena = '0; m_pend = '0; m_mask = '0; m_to = 1'b0; m_seq = 1'b0;
      e_rd = 32'd0; e_err = 1'b0;
    end else begin
      n_ena = m_ena; n_pend = m_pend; n_to = m_to;
      wbits = mem_wdata_i[CH-1:0];
      if (mem_ena_i) begin
        ok = (mem_addr_i[1:0] == 2'b00) && (mem_addr_i < 13'd16);
        e_err = !ok;
        if (!mem_wena_i) e_rd = ok ? model_read(mem_addr_i[3:2]) : 32'd0;
        else if (ok) begin
          if (mem_addr_i[3:2] == 2'd0) n_ena = wbits;
          if (mem_addr_i[3:2] == 2'd2) n_pend = n_pend | wbits;
          if (mem_addr_i[3:2] == 2'd3 && mem_wdata_i[1]) n_to = 1'b0;
        end
      end
      if (!m_seq) begin
        if (n_pend != '0) begin
          m_seq = 1'b1; m_mask = n_pend; n_pend = '0; t0 = c; done_c = -1;
        end
      end else if (done_c == p) begin
        m_seq = 1'b0; m_mask = '0;
      end else if (p >= t0 + R && done_c < 0) begin
        if ((busy_i & m_mask) == '0) done_c = c;
        else if (TO_EN && (p - (t0 + R) + 1) >= TO) begin
          done_c = c; n_to = 1'b1;
        end
      end
      m_ena = n_ena; m_pend = n_pend; m_to = n_to;
    end
    #1;
    e_srst = (m_seq && c < t0 + R) ? m_mask : '0;
    check_eq("rdata", mem_rdata_o, e_rd);
    check_eq("err", 32'(mem_err_o), 32'(e_err));
    check_eq("ena_o", 32'(ena_o), 32'(m_ena & ~m_mask));
    check_eq("soft_rst_o", 32'(soft_rst_o), 32'(e_srst));
    check_eq("seq_done", 32'(seq_done_o), 32'(m_seq && done_c == c));
    if (soft_rst_o != '0) n_srst_hi++;
    if (ena_o != 4'hF) n_masked++;
    if (seq_done_o) n_done++;
  endtask

  task automatic bus(input logic wr, input logic [AW-1:0] a, input logic [31:0] d);
    mem_ena_i = 1'b1; mem_wena_i = wr; mem_addr_i = a; mem_wdata_i = d;
    step();
    mem_ena_i = 1'b0; mem_wena_i = 1'b0;
  endtask

  initial begin
    main_rst_i = 1'b1; soft_rst_i = 1'b0; mem_ena_i = 1'b0; mem_wena_i = 1'b0;
    mem_addr_i = '0; mem_wdata_i = 32'd0; busy_i = '0;
    step(); step();
    main_rst_i = 1'b0;
    step();
    for (int i = 0; i < 4; i++) bus(1'b0, 13'(i * 4), 32'd0);

    // Basic sequence on channel 1 with no busy.
    bus(1'b1, 13'h0, 32'hF);
    n_srst_hi = 0; n_masked = 0; n_done = 0;
    bus(1'b1, 13'h8, 32'h2);
    repeat (12) step();
    check_eq("srst_len", 32'(n_srst_hi), 32'(R));
    check_eq("mask_len", 32'(n_masked), 32'(R + 2));
    check_eq("done_cnt", 32'(n_done), 32'd1);

    // Busy held through WAIT, SRST read mid-sequence.
    busy_i = 4'h2;
    bus(1'b1, 13'h8, 32'h2);
    repeat (R + 3) step();
    bus(1'b0, 13'h8, 32'd0);
    repeat (6) step();
    busy_i = 4'h0;
    repeat (4) step();

    // Second request queued behind an active one.
    busy_i = 4'h2;
    bus(1'b1, 13'h8, 32'h2);
    repeat (3) step();
    bus(1'b1, 13'h8, 32'h1);
    repeat (5) step();
    busy_i = 4'h0;
    repeat (16) step();

    if (TO_EN) begin
      busy_i = 4'hF;
      bus(1'b1, 13'h8, 32'h1);
      repeat (R + TO + 4) step();
      bus(1'b0, 13'hC, 32'd0);
      check_eq("status_to", mem_rdata_o, 32'h2);
      bus(1'b1, 13'hC, 32'h2);
      bus(1'b0, 13'hC, 32'd0);
      check_eq("status_clr", mem_rdata_o, 32'h0);
      busy_i = 4'h0;
    end

    // Error accesses and a global soft reset in the middle of a sequence.
    bus(1'b0, 13'h10, 32'd0);
    check_eq("err_hi", 32'(mem_err_o), 32'd1);
    bus(1'b0, 13'h2, 32'd0);
    check_eq("err_lo_rd", mem_rdata_o, 32'd0);
    bus(1'b1, 13'h10, 32'h3);
    bus(1'b0, 13'h0, 32'd0);
    check_eq("ctrl_keep", mem_rdata_o, 32'hF);
    busy_i = 4'h1;
    bus(1'b1, 13'h8, 32'h1);
    step();
    soft_rst_i = 1'b1;
    step();
    soft_rst_i = 1'b0;
    busy_i = 4'h0;
    repeat (8) step();

    for (int i = 0; i < 2000; i++) begin
      int sel;
      sel = $urandom_range(0, 5);
      mem_ena_i   = 1'($urandom_range(0, 1));
      mem_wena_i  = 1'($urandom_range(0, 1));
      mem_addr_i  = (sel < 4) ? 13'(sel * 4) : 13'($urandom);
      mem_wdata_i = $urandom;
      busy_i      = 4'($urandom & $urandom & $urandom);
      main_rst_i  = ($urandom_range(0, 299) == 0);
      soft_rst_i  = ($urandom_range(0, 199) == 0);
      step();
    end
    mem_ena_i = 1'b0; main_rst_i = 1'b0; soft_rst_i = 1'b0; busy_i = '0;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
